// File: rtl/fir_pkg.sv
// Shared types and elaboration-time helpers for the multichannel FIR filter.
package fir_pkg;

  typedef enum logic [1:0] {IDLE, MAC, OUT} fir_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Full-precision accumulator: TAPS products can never overflow it.
  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + clog2(taps);
  endfunction

  // Unity pass-through: only tap 0 is set, to 1.0 in the OUT_SHIFT fixed-point scale.
  function automatic int reset_coef(input int tap, input int out_shift);
    return (tap == 0) ? (1 << out_shift) : 0;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Shared multiply-accumulate with round-half-up, arithmetic shift and output narrowing.
// FIR_SAT_EN selects saturation; otherwise the result wraps to DATA_W bits.
module fir_mac
  import fir_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 8,
  parameter int OUT_SHIFT = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic                     clear,
  input  logic                     acc_en,
  input  logic signed [COEF_W-1:0] coef,
  input  logic signed [DATA_W-1:0] samp,
  output logic signed [DATA_W-1:0] result
);
  localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
  localparam int PW    = DATA_W + COEF_W;
  localparam logic signed [ACC_W:0] HALF = (ACC_W + 1)'(1) << (OUT_SHIFT - 1);

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W:0]   rounded;

  assign prod     = PW'(coef) * PW'(samp);
  assign acc_next = acc_en ? acc_reg + ACC_W'(prod) : acc_reg;
  // One extra bit so adding the rounding constant cannot wrap.
  assign rounded  = {acc_next[ACC_W-1], acc_next} + HALF;

`ifdef FIR_SAT_EN
  logic signed [ACC_W:0] shifted;
  assign shifted = rounded >>> OUT_SHIFT;

  always_comb begin
    result = shifted[DATA_W-1:0];
    if (!((&shifted[ACC_W:DATA_W-1]) || !(|shifted[ACC_W:DATA_W-1])))
      result = shifted[ACC_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end
`else
  assign result = DATA_W'(rounded >>> OUT_SHIFT);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_reg <= '0;
    end else if (ce) begin
      acc_reg <= clear ? '0 : acc_next;
    end
  end

endmodule

// File: rtl/fir_mc_filter.sv
// Time-multiplexed multichannel FIR: FSM, per-channel delay lines, coefficient bank, handshakes.
// Optional FIR_SAT_EN (in fir_mac) saturates the output instead of wrapping.
module fir_mc_filter
  import fir_pkg::*;
#(
  parameter int  DATA_W    = 32,
  parameter int  COEF_W    = 16,
  parameter int  TAPS      = 8,
  parameter int  CHANNELS  = 2,
  parameter int  OUT_SHIFT = 14,
  localparam int CH_W      = (clog2(CHANNELS) > 1) ? clog2(CHANNELS) : 1,
  localparam int AW        = clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_chan,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_chan,
  output logic signed [DATA_W-1:0] out_data,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_data
);
  localparam int KW = clog2(TAPS + 1);

  fir_state_t              state_reg;
  logic [KW-1:0]           tap_reg;
  logic [CH_W-1:0]         chan_reg;
  logic signed [COEF_W-1:0] coef_mem [TAPS];
  logic signed [DATA_W-1:0] dline [CHANNELS][TAPS];
  logic signed [COEF_W-1:0] coef_rd_reg;
  logic signed [DATA_W-1:0] samp_rd_reg;
  logic                    rd_valid_reg;
  logic                    in_ready_reg;
  logic                    out_valid_reg;
  logic [CH_W-1:0]         out_chan_reg;
  logic signed [DATA_W-1:0] out_data_reg;
  logic signed [DATA_W-1:0] mac_result;
  logic                    accept;
  logic                    chan_ok;

  assign chan_ok   = int'(in_chan) < CHANNELS;
  assign accept    = ce && in_valid && in_ready_reg && (state_reg == IDLE);
  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_chan  = out_chan_reg;
  assign out_data  = out_data_reg;

  fir_mac #(
    .DATA_W   (DATA_W),
    .COEF_W   (COEF_W),
    .TAPS     (TAPS),
    .OUT_SHIFT(OUT_SHIFT)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .ce    (ce),
    .clear (accept && chan_ok),
    .acc_en(rd_valid_reg),
    .coef  (coef_rd_reg),
    .samp  (samp_rd_reg),
    .result(mac_result)
  );

  // Tap reads are registered, so MAC runs one extra step (tap_reg == TAPS) to fold in the last product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      tap_reg       <= '0;
      chan_reg      <= '0;
      coef_rd_reg   <= '0;
      samp_rd_reg   <= '0;
      rd_valid_reg  <= 1'b0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_chan_reg  <= '0;
      out_data_reg  <= '0;
      for (int t = 0; t < TAPS; t++) coef_mem[t] <= COEF_W'(reset_coef(t, OUT_SHIFT));
      for (int c = 0; c < CHANNELS; c++)
        for (int t = 0; t < TAPS; t++) dline[c][t] <= '0;
    end else if (ce) begin
      rd_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          in_ready_reg <= 1'b1;
          if (coef_we) coef_mem[coef_addr] <= coef_data;
          if (accept && chan_ok) begin
            for (int c = 0; c < CHANNELS; c++) begin
              if (in_chan == CH_W'(c)) begin
                dline[c][0] <= in_data;
                for (int t = 1; t < TAPS; t++) dline[c][t] <= dline[c][t-1];
              end
            end
            chan_reg     <= in_chan;
            tap_reg      <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= MAC;
          end
        end
        MAC: begin
          if (tap_reg == KW'(TAPS)) begin
            out_data_reg  <= mac_result;
            out_chan_reg  <= chan_reg;
            out_valid_reg <= 1'b1;
            state_reg     <= OUT;
          end else begin
            coef_rd_reg  <= coef_mem[tap_reg[AW-1:0]];
            samp_rd_reg  <= dline[chan_reg][tap_reg[AW-1:0]];
            rd_valid_reg <= 1'b1;
            tap_reg      <= tap_reg + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mc_filter.sv
// Directed self-checking bench for fir_mc_filter (default parameters, optional FIR_SAT_EN).
module tb_fir_mc_filter;
  localparam int DATA_W = 32;
  localparam int COEF_W = 16;
  localparam int TAPS   = 8;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     ce = 1'b1;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [0:0]               in_chan = '0;
  logic signed [DATA_W-1:0] in_data = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic [0:0]               out_chan;
  logic signed [DATA_W-1:0] out_data;
  logic                     coef_we = 1'b0;
  logic [2:0]               coef_addr = '0;
  logic signed [COEF_W-1:0] coef_data = '0;

  int total = 0;
  int bad = 0;
  int xfer_count = 0;

  fir_mc_filter dut (
    .clk(clk), .rst(rst), .ce(ce),
    .in_valid(in_valid), .in_ready(in_ready), .in_chan(in_chan), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan), .out_data(out_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (out_valid && out_ready && ce) xfer_count <= xfer_count + 1;

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic write_coef(input int addr, input int val);
    @(negedge clk);
    coef_we = 1'b1;
    coef_addr = 3'(addr);
    coef_data = COEF_W'(val);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  // Offers one sample, waits for its result with out_ready high; x on timeout.
  task automatic run_sample(input int ch, input int d, output logic signed [DATA_W-1:0] rd,
                            output logic [0:0] rc, output int lat);
    int n;
    rd = 'x;
    rc = 'x;
    lat = -1;
    @(negedge clk);
    in_chan = 1'(ch);
    in_data = DATA_W'(d);
    in_valid = 1'b1;
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (n < 50) begin
      @(posedge clk);
      n++;
      #1;
      if (out_valid) begin
        rd = out_data;
        rc = out_chan;
        lat = n;
        break;
      end
    end
    @(posedge clk);
    #1;
    $display("txn chan=%0d in=%0d out=%0d out_chan=%0d latency=%0d", ch, d, rd, rc, lat);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
    total++; if (out_chan !== 1'b0) begin bad++; $display("FAIL reset_out_chan got=%0d want=0", out_chan); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_passthrough();
    logic signed [DATA_W-1:0] rd;
    logic [0:0] rc;
    int lat;
    run_sample(0, 1234, rd, rc, lat);
    total++; if (rd !== 1234) begin bad++; $display("FAIL passthrough_data got=%0d want=1234", rd); end
    total++; if (rc !== 1'b0) begin bad++; $display("FAIL passthrough_chan got=%0d want=0", rc); end
    total++; if (lat !== TAPS + 1) begin bad++; $display("FAIL passthrough_latency got=%0d want=%0d", lat, TAPS + 1); end
  endtask

  task automatic test_moving_sum();
    int vals[5] = '{10, 20, 30, 40, 50};
    int exps[5] = '{10, 30, 60, 100, 140};
    logic signed [DATA_W-1:0] rd;
    logic [0:0] rc;
    int lat;
    for (int t = 1; t < 4; t++) write_coef(t, 16384);
    for (int i = 0; i < 5; i++) begin
      run_sample(1, vals[i], rd, rc, lat);
      total++; if (rd !== DATA_W'(exps[i])) begin bad++; $display("FAIL moving_sum[%0d] got=%0d want=%0d", i, rd, exps[i]); end
      total++; if (rc !== 1'b1) begin bad++; $display("FAIL moving_sum_chan[%0d] got=%0d want=1", i, rc); end
    end
  endtask

  task automatic test_isolation();
    int chs[4]  = '{0, 1, 0, 1};
    int vals[4] = '{100, 7, 100, 7};
    int exps[4] = '{100, 7, 200, 14};
    logic signed [DATA_W-1:0] rd;
    logic [0:0] rc;
    int lat;
    apply_reset();
    for (int t = 1; t < 4; t++) write_coef(t, 16384);
    for (int i = 0; i < 4; i++) begin
      run_sample(chs[i], vals[i], rd, rc, lat);
      total++; if (rd !== DATA_W'(exps[i])) begin bad++; $display("FAIL isolation[%0d] got=%0d want=%0d", i, rd, exps[i]); end
      total++; if (rc !== 1'(chs[i])) begin bad++; $display("FAIL isolation_chan[%0d] got=%0d want=%0d", i, rc, chs[i]); end
    end
  endtask

  // Channel 0 holds 100,100 with a 4-tap moving sum, so sample 50 yields 250.
  task automatic test_backpressure();
    int n;
    int xfer_start;
    @(negedge clk);
    out_ready = 1'b0;
    in_chan = 1'b0;
    in_data = 50;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_wait_valid got=%b want=1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (out_data !== 250) begin bad++; $display("FAIL bp_hold_data[%0d] got=%0d want=250", i, out_data); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b want=0", i, in_ready); end
    end
    xfer_start = xfer_count;
    ce = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ce_hold_valid[%0d] got=%b want=1", i, out_valid); end
    end
    total++; if (xfer_count !== xfer_start) begin bad++; $display("FAIL ce_no_xfer got=%0d want=%0d", xfer_count - xfer_start, 0); end
    ce = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (xfer_count - xfer_start !== 1) begin bad++; $display("FAIL ce_one_xfer got=%0d want=1", xfer_count - xfer_start); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ce_after_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ce_after_ready got=%b want=1", in_ready); end
    $display("txn backpressure chan=0 in=50 out=250 transfers=%0d", xfer_count - xfer_start);
  endtask

  task automatic test_saturation();
    logic signed [DATA_W-1:0] rd;
    logic signed [DATA_W-1:0] want;
    logic [0:0] rc;
    int lat;
`ifdef FIR_SAT_EN
    want = 32'sd2147483647;
`else
    want = -32'sd131074;
`endif
    apply_reset();
    write_coef(0, 32767);
    run_sample(0, 2147483647, rd, rc, lat);
    total++; if (rd !== want) begin bad++; $display("FAIL saturation got=%0d want=%0d", rd, want); end
  endtask

  task automatic test_mid_events();
    logic signed [DATA_W-1:0] rd;
    logic [0:0] rc;
    int lat;
    int n;
    int valid_seen;
    apply_reset();
    // Coefficient write while MAC is running must be ignored.
    @(negedge clk);
    in_chan = 1'b0;
    in_data = 500;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    coef_we = 1'b1;
    coef_addr = 3'd0;
    coef_data = 16'sd32767;
    repeat (2) @(negedge clk);
    coef_we = 1'b0;
    n = 0;
    rd = 'x;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (out_valid) begin rd = out_data; break; end
    end
    total++; if (rd !== 500) begin bad++; $display("FAIL mac_write_dropped got=%0d want=500", rd); end
    $display("txn chan=0 in=500 out=%0d (write during MAC)", rd);
    run_sample(0, 300, rd, rc, lat);
    total++; if (rd !== 300) begin bad++; $display("FAIL mac_write_dropped_next got=%0d want=300", rd); end
    write_coef(0, 8192);
    run_sample(0, 600, rd, rc, lat);
    total++; if (rd !== 300) begin bad++; $display("FAIL idle_write_half got=%0d want=300", rd); end
    // Reset pulse in the middle of MAC.
    @(negedge clk);
    in_data = 400;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_in_ready got=%b want=0", in_ready); end
    rst = 1'b1;
    valid_seen = 0;
    for (int i = 0; i < TAPS + 6; i++) begin
      @(negedge clk);
      if (out_valid) valid_seen++;
    end
    total++; if (valid_seen !== 0) begin bad++; $display("FAIL midrst_no_output got=%0d want=0", valid_seen); end
    run_sample(0, 600, rd, rc, lat);
    total++; if (rd !== 600) begin bad++; $display("FAIL midrst_coef_restored got=%0d want=600", rd); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_moving_sum();
    test_isolation();
    test_backpressure();
    test_saturation();
    test_mid_events();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
